intersection_scheduler: RTL and testbench
=========================================

// Module: intersection_scheduler
// PURPOSE
//  Sequences two traffic_light-style signal heads (north-south, east-west) at one
//  intersection, so that exactly one direction holds right-of-way at a time.
//  Latches crossing requests from the red direction. Cuts the current green short
//  once a minimum green time has elapsed. Inserts all-red clearance between directions.
//  Sits above the per-head lamp drivers and owns all R/G/Y decode for both heads.
// PARAMETERS
//  CNT_W      12    width of phase cycle counter
//  GREEN_CYC  1024  maximum green duration, cycles
//  MIN_GREEN  256   minimum green before a pending request may end green
//  YELLOW_CYC 512   yellow duration, cycles
//  CLEAR_CYC  64    all-red clearance duration, cycles
//  BLINK_CYC  128   blink half-period; used only with GREEN_BLINK_EN
// PORTS
//  clk     in   1  clock; all logic on posedge
//  rst     in   1  reset, synchronous, active-high
//  req_ns  in   1  crossing request for NS right-of-way; level or pulse, sampled each clk
//  req_ew  in   1  crossing request for EW right-of-way
//  ns_r/ns_g/ns_y  out 1  NS lamp drives, one-hot or all-zero
//  ew_r/ew_g/ew_y  out 1  EW lamp drives
//  phase   out  3  current state encoding (see BEHAVIOUR)
//  pend_ns out  1  registered NS pending-request flag
//  pend_ew out  1  registered EW pending-request flag
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high.
//  - Reset: state=NS_G, cnt=0, pend_ns=pend_ew=0.
//      Resulting outputs: ns_g=1, ew_r=1, all other lamps 0, phase=0.
//      Reset mid-phase behaves identically; no yellow or clearance is inserted.
//  - Phase encoding:
//      0 NS_G, 1 NS_B, 2 NS_Y, 3 RED_A, 4 EW_G, 5 EW_B, 6 EW_Y, 7 RED_B.
//      NS_B and EW_B are reachable only with GREEN_BLINK_EN.
//  - Phase order: NS_G -> [NS_B] -> NS_Y -> RED_A -> EW_G -> [EW_B] -> EW_Y -> RED_B -> NS_G.
//  - Counter:
//      cnt clears to 0 on every state entry and increments by 1 each cycle otherwise.
//      A state of length N exits at the edge where cnt==N-1.
//      All durations are <= 2^CNT_W, so cnt never wraps.
//  - Green exit (X=current green direction, O=other direction): leave X_G at the edge where
//      (cnt==GREEN_CYC-1) OR (pend_O && cnt>=MIN_GREEN-1).
//      If there is no request, green still ends at GREEN_CYC; there is no green rest.
//  - Pending latch:
//      pend_X sets on any cycle with req_X=1, except when X_G or X_B is current
//      or is being entered on that edge.
//      pend_X clears on entry to X_G; the clear takes priority over a same-cycle req_X.
//      Requests during yellow, blink or clearance are latched normally.
//  - Request latency: req_O is sampled at cycle t, so pend_O is visible at t+1.
//      Yellow appears no earlier than t+2, and never before cnt reaches MIN_GREEN.
//  - Simultaneous req_ns and req_ew: only the red side latches; the green side's request is dropped.
//  - Lamp decode is combinational from state (and cnt in blink), so lamps change in the
//      same cycle as phase.
//      X_G: X green, O red. X_Y: X yellow, O red. RED_A/RED_B: both red.
//      ns_g and ew_g are never 1 in the same cycle.
// CONFIGURATION
//  GREEN_BLINK_EN defined:
//      After X_G exits (for either reason), the block enters X_B for 4*BLINK_CYC cycles, then X_Y.
//      In X_B, X's green lamp is 0 when cnt/BLINK_CYC is 0 or 2, and 1 when it is 1 or 3.
//      O stays red for the whole of X_B.
//      Pending requests for O are already satisfied, so X_B is never cut short.
//  GREEN_BLINK_EN undefined:
//      X_G goes directly to X_Y; phases 1 and 5 are never produced.
// TESTING  (cycle 0 = first cycle with rst=0)
//  1. Hold rst 3 cycles -> in every reset cycle and at cycle 0:
//       ns_g=1, ew_r=1, phase=0, pend_*=0.
//  2. No requests -> NS_Y during cycles 1024-1535, RED_A 1536-1599, EW_G from 1600,
//       EW_Y from 2624, NS_G again at 3200.
//  3. req_ew pulse at cycle 10 -> pend_ew=1 from cycle 11; ns_y=1 at cycle 256;
//       pend_ew=0 from cycle 832 (EW_G).
//  4. req_ew pulse at cycle 600 -> ns_y=1 at cycle 602.
//     Also: req_ns held high throughout -> pend_ns stays 0 while NS is green.
//  5. rst pulse at cycle 1700 (EW_G) -> at cycle 1701: phase=0, ns_g=1, ew_r=1, pend_*=0.
//     Also: req_ns and req_ew asserted together at cycle 5 -> only pend_ew sets.
//  6. GREEN_BLINK_EN, no requests -> ns_g pattern:
//       0 during 1024-1151, 1 during 1152-1279, 0 during 1280-1407, 1 during 1408-1535.
//       ns_y during 1536-2047; EW_G at 2112.

Source files
------------

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: two-head (NS/EW) intersection sequencer.
//   Order: NS_G -> [NS_B] -> NS_Y -> RED_A -> EW_G -> [EW_B] -> EW_Y -> RED_B.
//   Green ends at GREEN_CYC, or early once MIN_GREEN has elapsed and the
//   red side has a latched request. All-red clearance between directions.
// Ports:
//   clk, rst (sync, active-high), req_ns, req_ew   : inputs
//   ns_r/ns_g/ns_y, ew_r/ew_g/ew_y                 : lamp drives
//   phase[2:0]                                     : current state encoding
//   pend_ns, pend_ew                               : latched request flags
// Optional: GREEN_BLINK_EN inserts a blinking-green phase after each green.
module intersection_scheduler #(
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned GREEN_CYC  = 1024,
  parameter int unsigned MIN_GREEN  = 256,
  parameter int unsigned YELLOW_CYC = 512,
  parameter int unsigned CLEAR_CYC  = 64,
  parameter int unsigned BLINK_CYC  = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_ns,
  input  logic       req_ew,
  output logic       ns_r,
  output logic       ns_g,
  output logic       ns_y,
  output logic       ew_r,
  output logic       ew_g,
  output logic       ew_y,
  output logic [2:0] phase,
  output logic       pend_ns,
  output logic       pend_ew
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_B  = 3'd1,
    NS_Y  = 3'd2,
    RED_A = 3'd3,
    EW_G  = 3'd4,
    EW_B  = 3'd5,
    EW_Y  = 3'd6,
    RED_B = 3'd7
  } state_t;

`ifdef GREEN_BLINK_EN
  localparam state_t NS_AFTER_G = NS_B;
  localparam state_t EW_AFTER_G = EW_B;
`else
  localparam state_t NS_AFTER_G = NS_Y;
  localparam state_t EW_AFTER_G = EW_Y;
`endif

  localparam int unsigned BLINK_LEN = 4 * BLINK_CYC;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend_ns;
  logic             r_pend_ew;
  logic             w_pend_ns_nxt;
  logic             w_pend_ew_nxt;
  logic             w_ns_exit;
  logic             w_ew_exit;
  logic             w_blink_on;
  logic             w_entering;

  assign w_ns_exit = (r_cnt == CNT_W'(GREEN_CYC - 1)) ||
                     (r_pend_ew && (r_cnt >= CNT_W'(MIN_GREEN - 1)));
  assign w_ew_exit = (r_cnt == CNT_W'(GREEN_CYC - 1)) ||
                     (r_pend_ns && (r_cnt >= CNT_W'(MIN_GREEN - 1)));

  // Lamp is off in blink quarters 0 and 2, on in quarters 1 and 3.
  assign w_blink_on = ((r_cnt / CNT_W'(BLINK_CYC)) & CNT_W'(1)) != '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      NS_G:    if (w_ns_exit) w_next = NS_AFTER_G;
      NS_B:    if (r_cnt == CNT_W'(BLINK_LEN - 1)) w_next = NS_Y;
      NS_Y:    if (r_cnt == CNT_W'(YELLOW_CYC - 1)) w_next = RED_A;
      RED_A:   if (r_cnt == CNT_W'(CLEAR_CYC - 1)) w_next = EW_G;
      EW_G:    if (w_ew_exit) w_next = EW_AFTER_G;
      EW_B:    if (r_cnt == CNT_W'(BLINK_LEN - 1)) w_next = EW_Y;
      EW_Y:    if (r_cnt == CNT_W'(YELLOW_CYC - 1)) w_next = RED_B;
      RED_B:   if (r_cnt == CNT_W'(CLEAR_CYC - 1)) w_next = NS_G;
      default: w_next = NS_G;
    endcase
  end

  assign w_entering = (w_next != r_state);

  // Entry clear beats a same-cycle request; the green/blink side never latches.
  always_comb begin
    w_pend_ns_nxt = r_pend_ns;
    if (w_next == NS_G && r_state != NS_G)
      w_pend_ns_nxt = 1'b0;
    else if (req_ns && !(r_state inside {NS_G, NS_B}) && !(w_next inside {NS_G, NS_B}))
      w_pend_ns_nxt = 1'b1;

    w_pend_ew_nxt = r_pend_ew;
    if (w_next == EW_G && r_state != EW_G)
      w_pend_ew_nxt = 1'b0;
    else if (req_ew && !(r_state inside {EW_G, EW_B}) && !(w_next inside {EW_G, EW_B}))
      w_pend_ew_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= NS_G;
      r_cnt     <= '0;
      r_pend_ns <= 1'b0;
      r_pend_ew <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_entering ? '0 : r_cnt + CNT_W'(1);
      r_pend_ns <= w_pend_ns_nxt;
      r_pend_ew <= w_pend_ew_nxt;
    end
  end

  always_comb begin
    ns_r = 1'b0;
    ns_g = 1'b0;
    ns_y = 1'b0;
    ew_r = 1'b0;
    ew_g = 1'b0;
    ew_y = 1'b0;
    case (r_state)
      NS_G:  begin ns_g = 1'b1;       ew_r = 1'b1; end
      NS_B:  begin ns_g = w_blink_on; ew_r = 1'b1; end
      NS_Y:  begin ns_y = 1'b1;       ew_r = 1'b1; end
      EW_G:  begin ew_g = 1'b1;       ns_r = 1'b1; end
      EW_B:  begin ew_g = w_blink_on; ns_r = 1'b1; end
      EW_Y:  begin ew_y = 1'b1;       ns_r = 1'b1; end
      default: begin ns_r = 1'b1;     ew_r = 1'b1; end
    endcase
  end

  assign phase   = r_state;
  assign pend_ns = r_pend_ns;
  assign pend_ew = r_pend_ew;

endmodule

// File: tb/tb_intersection_scheduler.sv
module tb_intersection_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_ns;
  logic       req_ew;
  logic       ns_r, ns_g, ns_y, ew_r, ew_g, ew_y;
  logic [2:0] phase;
  logic       pend_ns, pend_ew;

  intersection_scheduler #(
    .CNT_W      (12),
    .GREEN_CYC  (1024),
    .MIN_GREEN  (256),
    .YELLOW_CYC (512),
    .CLEAR_CYC  (64),
    .BLINK_CYC  (128)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_ns  (req_ns),
    .req_ew  (req_ew),
    .ns_r    (ns_r),
    .ns_g    (ns_g),
    .ns_y    (ns_y),
    .ew_r    (ew_r),
    .ew_g    (ew_g),
    .ew_y    (ew_y),
    .phase   (phase),
    .pend_ns (pend_ns),
    .pend_ew (pend_ew)
  );

  always #5 clk = ~clk;

  localparam int F_PHASE = 0;
  localparam int F_LAMPS = 1;
  localparam int F_PNS   = 2;
  localparam int F_PEW   = 3;

  // Lamp vector order: {ns_r, ns_g, ns_y, ew_r, ew_g, ew_y}
  localparam logic [5:0] L_NSG = 6'b010100;
  localparam logic [5:0] L_NSY = 6'b001100;
  localparam logic [5:0] L_RED = 6'b100100;
  localparam logic [5:0] L_EWG = 6'b100010;
  localparam logic [5:0] L_EWY = 6'b100001;
  localparam logic [5:0] L_NSB_OFF = 6'b000100;

  typedef struct {
    int         cyc;
    int         fld;
    logic [5:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [5:0] lamp_of(input logic [2:0] p);
    case (p)
      3'd0:    return L_NSG;
      3'd2:    return L_NSY;
      3'd4:    return L_EWG;
      3'd6:    return L_EWY;
      default: return L_RED;
    endcase
  endfunction

  function automatic logic [5:0] observe(input int f);
    case (f)
      F_PHASE: return {3'b000, phase};
      F_LAMPS: return {ns_r, ns_g, ns_y, ew_r, ew_g, ew_y};
      F_PNS:   return {5'b00000, pend_ns};
      default: return {5'b00000, pend_ew};
    endcase
  endfunction

  task automatic push(input int c, input int f, input logic [5:0] v, input string n);
    exp_t e;
    e.cyc = c; e.fld = f; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic push_phase(input int c, input logic [2:0] p, input string n);
    push(c, F_PHASE, {3'b000, p}, n);
    push(c, F_LAMPS, lamp_of(p), {n, "_lamps"});
  endtask

  task automatic apply_reset;
    rst = 1'b1; req_ns = 1'b0; req_ew = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_ns = 1'b0; req_ew = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) @(negedge clk);
      else begin rst = 1'b0; cyc = 0; end
      n_total++;
      if (phase !== 3'd0) $display("FAIL reset_phase step=%0d got=%0d exp=0", i, phase);
      else n_pass++;
      n_total++;
      if ({ns_r, ns_g, ns_y, ew_r, ew_g, ew_y} !== L_NSG)
        $display("FAIL reset_lamps step=%0d got=%b exp=%b", i, {ns_r, ns_g, ns_y, ew_r, ew_g, ew_y}, L_NSG);
      else n_pass++;
      n_total++;
      if ({pend_ns, pend_ew} !== 2'b00) $display("FAIL reset_pend step=%0d got=%b exp=00", i, {pend_ns, pend_ew});
      else n_pass++;
    end
    @(negedge clk); cyc++;
    n_total++;
    if (phase !== 3'd0) $display("FAIL reset_cyc1_phase got=%0d exp=0", phase);
    else n_pass++;
  endtask

  task automatic test_no_requests;
    exp_t e;
    apply_reset();
    push_phase(0, 3'd0, "nr_c0");
    push_phase(1023, 3'd0, "nr_nsg_last");
    push_phase(1024, 3'd2, "nr_nsy_first");
    push_phase(1535, 3'd2, "nr_nsy_last");
    push_phase(1536, 3'd3, "nr_reda_first");
    push_phase(1599, 3'd3, "nr_reda_last");
    push_phase(1600, 3'd4, "nr_ewg_first");
    push_phase(2623, 3'd4, "nr_ewg_last");
    push_phase(2624, 3'd6, "nr_ewy_first");
    push_phase(3135, 3'd6, "nr_ewy_last");
    push_phase(3136, 3'd7, "nr_redb_first");
    push_phase(3199, 3'd7, "nr_redb_last");
    push_phase(3200, 3'd0, "nr_nsg_again");
    push(3200, F_PNS, 6'd0, "nr_pend_ns");
    push(3200, F_PEW, 6'd0, "nr_pend_ew");
    for (int k = 0; k <= 3202; k++) begin
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_total++;
        if (observe(e.fld) !== e.val)
          $display("FAIL %s cyc=%0d got=%0h exp=%0h", e.name, cyc, observe(e.fld), e.val);
        else n_pass++;
      end
      n_total++;
      if ((ns_g & ew_g) !== 1'b0) $display("FAIL nr_both_green cyc=%0d got=1 exp=0", cyc);
      else n_pass++;
      req_ns = 1'b0; req_ew = 1'b0;
      @(negedge clk); cyc++;
    end
    n_total++;
    if (sb.size() !== 0) begin $display("FAIL nr_unchecked got=%0d exp=0", sb.size()); sb.delete(); end
    else n_pass++;
  endtask

  task automatic test_req_early;
    exp_t e;
    apply_reset();
    push(10, F_PEW, 6'd0, "re_pew_before");
    push(11, F_PEW, 6'd1, "re_pew_set");
    push_phase(255, 3'd0, "re_nsg_last");
    push_phase(256, 3'd2, "re_nsy_first");
    push_phase(767, 3'd2, "re_nsy_last");
    push_phase(768, 3'd3, "re_reda_first");
    push(831, F_PEW, 6'd1, "re_pew_held");
    push_phase(832, 3'd4, "re_ewg_first");
    push(832, F_PEW, 6'd0, "re_pew_clear");
    for (int k = 0; k <= 834; k++) begin
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_total++;
        if (observe(e.fld) !== e.val)
          $display("FAIL %s cyc=%0d got=%0h exp=%0h", e.name, cyc, observe(e.fld), e.val);
        else n_pass++;
      end
      req_ns = 1'b0;
      req_ew = (cyc == 10);
      @(negedge clk); cyc++;
    end
    n_total++;
    if (sb.size() !== 0) begin $display("FAIL re_unchecked got=%0d exp=0", sb.size()); sb.delete(); end
    else n_pass++;
  endtask

  task automatic test_req_late;
    exp_t e;
    apply_reset();
    push(1, F_PNS, 6'd0, "rl_pns_green1");
    push(300, F_PNS, 6'd0, "rl_pns_green300");
    push(600, F_PEW, 6'd0, "rl_pew_before");
    push_phase(601, 3'd0, "rl_nsg_last");
    push(601, F_PEW, 6'd1, "rl_pew_set");
    push(601, F_PNS, 6'd0, "rl_pns_green601");
    push_phase(602, 3'd2, "rl_nsy_first");
    push(602, F_PNS, 6'd0, "rl_pns_entry_y");
    push(603, F_PNS, 6'd1, "rl_pns_in_y");
    for (int k = 0; k <= 605; k++) begin
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_total++;
        if (observe(e.fld) !== e.val)
          $display("FAIL %s cyc=%0d got=%0h exp=%0h", e.name, cyc, observe(e.fld), e.val);
        else n_pass++;
      end
      req_ns = 1'b1;
      req_ew = (cyc == 600);
      @(negedge clk); cyc++;
    end
    n_total++;
    if (sb.size() !== 0) begin $display("FAIL rl_unchecked got=%0d exp=0", sb.size()); sb.delete(); end
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    exp_t e;
    apply_reset();
    push(6, F_PEW, 6'd1, "rm_both_pew");
    push(6, F_PNS, 6'd0, "rm_both_pns");
    push(1700, F_PHASE, 6'd4, "rm_ewg_phase");
    push(1700, F_PNS, 6'd1, "rm_pns_before");
    push_phase(1701, 3'd0, "rm_after_rst");
    push(1701, F_PNS, 6'd0, "rm_pns_after");
    push(1701, F_PEW, 6'd0, "rm_pew_after");
    push(1702, F_PHASE, 6'd0, "rm_stay_nsg");
    for (int k = 0; k <= 1703; k++) begin
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_total++;
        if (observe(e.fld) !== e.val)
          $display("FAIL %s cyc=%0d got=%0h exp=%0h", e.name, cyc, observe(e.fld), e.val);
        else n_pass++;
      end
      req_ns = (cyc == 5) || (cyc == 1699);
      req_ew = (cyc == 5);
      rst    = (cyc == 1700);
      @(negedge clk); cyc++;
    end
    rst = 1'b0;
    n_total++;
    if (sb.size() !== 0) begin $display("FAIL rm_unchecked got=%0d exp=0", sb.size()); sb.delete(); end
    else n_pass++;
  endtask

`ifdef GREEN_BLINK_EN
  task automatic test_blink;
    exp_t e;
    apply_reset();
    push_phase(1023, 3'd0, "bl_nsg_last");
    push(1024, F_PHASE, 6'd1, "bl_nsb_phase");
    push(1024, F_LAMPS, L_NSB_OFF, "bl_q0_first");
    push(1151, F_LAMPS, L_NSB_OFF, "bl_q0_last");
    push(1152, F_LAMPS, L_NSG, "bl_q1_first");
    push(1279, F_LAMPS, L_NSG, "bl_q1_last");
    push(1280, F_LAMPS, L_NSB_OFF, "bl_q2_first");
    push(1407, F_LAMPS, L_NSB_OFF, "bl_q2_last");
    push(1408, F_LAMPS, L_NSG, "bl_q3_first");
    push(1535, F_LAMPS, L_NSG, "bl_q3_last");
    push_phase(1536, 3'd2, "bl_nsy_first");
    push_phase(2047, 3'd2, "bl_nsy_last");
    push_phase(2048, 3'd3, "bl_reda_first");
    push_phase(2111, 3'd3, "bl_reda_last");
    push_phase(2112, 3'd4, "bl_ewg_first");
    for (int k = 0; k <= 2114; k++) begin
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_total++;
        if (observe(e.fld) !== e.val)
          $display("FAIL %s cyc=%0d got=%0h exp=%0h", e.name, cyc, observe(e.fld), e.val);
        else n_pass++;
      end
      n_total++;
      if ((ns_g & ew_g) !== 1'b0) $display("FAIL bl_both_green cyc=%0d got=1 exp=0", cyc);
      else n_pass++;
      req_ns = 1'b0; req_ew = 1'b0;
      @(negedge clk); cyc++;
    end
    n_total++;
    if (sb.size() !== 0) begin $display("FAIL bl_unchecked got=%0d exp=0", sb.size()); sb.delete(); end
    else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1; req_ns = 1'b0; req_ew = 1'b0; cyc = 0;
    test_reset();
`ifdef GREEN_BLINK_EN
    test_blink();
`else
    test_no_requests();
    test_req_early();
    test_req_late();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
